// File: rtl/lunar_pkg.sv
// Shared types and constants for the lunar-lander plant and its autopilot.
package lunar_pkg;

  localparam int NBITS_COMBUST = 8;
  localparam int NBITS_VELOCID = 12;
  localparam int NBITS_ALTURA  = 12;

  // Gravity term; must track the plant's value or the burn law drifts.
  localparam int ACEL_GRAVIT = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COAST   = 3'd1,
    BRAKE   = 3'd2,
    LANDED  = 3'd3,
    CRASHED = 3'd4
  } ap_state_t;

endpackage

// File: rtl/lunar_burn_law.sv
// Combinational burn law: chase a target descent speed proportional to altitude,
// saturated to the 7-bit command range and to the fuel left in the tank.
module lunar_burn_law
  import lunar_pkg::*;
#(
  parameter int TARGET_SHIFT = 3,
  parameter int V_TOUCH      = 2,
  parameter int MAX_BURN     = 127
) (
  input  logic        [NBITS_ALTURA-1:0]  altura,
  input  logic signed [NBITS_VELOCID-1:0] velocidade,
  input  logic        [NBITS_COMBUST-1:0] combustivel,
  output logic        [6:0]               burn
);

  // 14 bits covers the full range of altura>>shift, velocidade and the constants.
  localparam logic signed [13:0] VT_S  = 14'(V_TOUCH);
  localparam logic signed [13:0] AG_S  = 14'(ACEL_GRAVIT);
  localparam logic signed [13:0] MAX_S = 14'(MAX_BURN);

  logic signed [13:0] alt_sh, v_target, vel_s, fuel_s, raw, lim;

  assign alt_sh   = $signed({2'b00, altura >> TARGET_SHIFT});
  assign vel_s    = {{2{velocidade[NBITS_VELOCID-1]}}, velocidade};
  assign fuel_s   = $signed({6'b0, combustivel});
  assign v_target = -alt_sh - VT_S;
  assign raw      = v_target - vel_s + AG_S;

  // Positive error only: the engine cannot push the lander downward.
  always_comb begin
    burn = '0;
    lim  = raw;
    if (raw > 14'sd0) begin
      if (lim > MAX_S)  lim = MAX_S;
      if (lim > fuel_s) lim = fuel_s;
      burn = lim[6:0];
    end
  end

endmodule

// File: rtl/lunar_autopilot.sv
// Closed-loop autopilot: phase FSM (idle/coast/brake/touchdown) driving a
// registered burn command, touchdown verdict flags and a burn accumulator.
module lunar_autopilot
  import lunar_pkg::*;
#(
  parameter int ALT_BRAKE    = 200,
  parameter int V_COAST_MAX  = 80,
  parameter int TARGET_SHIFT = 3,
  parameter int V_TOUCH      = 2,
  parameter int V_SAFE       = 10,
  parameter int MAX_BURN     = 127
) (
  input  logic                            clk_2,
  input  logic                            reset,
  input  logic                            enable,
  input  logic        [NBITS_ALTURA-1:0]  altura,
  input  logic signed [NBITS_VELOCID-1:0] velocidade,
  input  logic        [NBITS_COMBUST-1:0] combustivel,
  output logic        [6:0]               decr_combust,
  output ap_state_t                       state,
  output logic                            landed,
  output logic                            crashed,
  output logic                            fuel_out,
  output logic        [15:0]              burn_total
);

  localparam logic        [NBITS_ALTURA-1:0]  ALT_BRAKE_U = NBITS_ALTURA'(ALT_BRAKE);
  localparam logic signed [NBITS_VELOCID-1:0] V_COAST_NEG = NBITS_VELOCID'(-V_COAST_MAX);
  localparam logic signed [NBITS_VELOCID-1:0] V_SAFE_NEG  = NBITS_VELOCID'(-V_SAFE);

  logic [6:0]  burn;
  logic [16:0] bt_sum;

  lunar_burn_law #(
    .TARGET_SHIFT(TARGET_SHIFT),
    .V_TOUCH     (V_TOUCH),
    .MAX_BURN    (MAX_BURN)
  ) u_burn_law (
    .altura     (altura),
    .velocidade (velocidade),
    .combustivel(combustivel),
    .burn       (burn)
  );

  // Accumulates the command already on the output, so it trails it by a cycle.
  assign bt_sum = {1'b0, burn_total} + {10'b0, decr_combust};

  // Phase FSM with registered command, sticky verdict flags and burn total.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state        <= IDLE;
      decr_combust <= '0;
      landed       <= 1'b0;
      crashed      <= 1'b0;
      fuel_out     <= 1'b0;
      burn_total   <= '0;
    end else begin
      burn_total   <= bt_sum[16] ? 16'hFFFF : bt_sum[15:0];
      decr_combust <= '0;
      case (state)
        IDLE: begin
          // No touchdown check while disengaged, even sitting at altura==0.
          if (enable) state <= COAST;
        end
        COAST, BRAKE: begin
          if (combustivel == '0 && altura != '0) fuel_out <= 1'b1;
          // Touchdown outranks disengage and phase changes.
          if (altura == '0) begin
            if (velocidade >= V_SAFE_NEG) begin
              state  <= LANDED;
              landed <= 1'b1;
            end else begin
              state   <= CRASHED;
              crashed <= 1'b1;
            end
          end else if (!enable) begin
            state <= IDLE;
          end else if (state == COAST) begin
            if (altura <= ALT_BRAKE_U || velocidade < V_COAST_NEG) state <= BRAKE;
          end else begin
            decr_combust <= burn;
          end
        end
        LANDED, CRASHED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
